// File: rtl/stream_median_filter.sv
// Sliding-window median filter: WIN-sample window, per-element rank counting, 3-stage pipeline.
// Optional MEDIAN_MINMAX_EN adds window min/max outputs aligned with out_data.

module median_rank #(
  parameter int DW  = 8,
  parameter int WIN = 5,
  parameter int IDX = 0
) (
  input  logic [WIN-1:0][DW-1:0] win_i,
  output logic [3:0]             rank_o
);
  // Ties are broken by position so the ranks always form a permutation.
  always_comb begin
    rank_o = '0;
    for (int j = 0; j < WIN; j++) begin
      if (j != IDX) begin
        if ((win_i[j] < win_i[IDX]) || ((win_i[j] == win_i[IDX]) && (j < IDX)))
          rank_o = rank_o + 4'd1;
      end
    end
  end
endmodule

module stream_median_filter #(
  parameter int DW  = 8,
  parameter int WIN = 5
) (
  input  logic          clk,
  input  logic          ngreset,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [3:0]    fill_cnt
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DW-1:0] out_min,
  output logic [DW-1:0] out_max
`endif
);
  localparam int          STAGES  = 3;
  localparam logic [3:0]  WIN_C   = 4'(WIN);
  localparam logic [3:0]  FULL_M1 = 4'(WIN - 1);
  localparam logic [3:0]  MID     = 4'((WIN - 1) / 2);

  if ((WIN % 2 == 0) || (WIN < 3) || (WIN > 15) || (DW < 2) || (DW > 32)) begin : g_bad_cfg
    $error("stream_median_filter: WIN must be odd in 3..15 and DW in 2..32");
  end

  logic [WIN-1:0][DW-1:0] win_q, ws1_q;
  logic [WIN-1:0][3:0]    rank_d, rank_q;
  logic [3:0]             fill_q;
  logic [STAGES-1:0]      vld_pipe_q;
  logic [DW-1:0]          out_data_q, med_d;

  for (genvar i = 0; i < WIN; i++) begin : g_rank
    median_rank #(.DW(DW), .WIN(WIN), .IDX(i)) u_rank (
      .win_i  (win_q),
      .rank_o (rank_d[i])
    );
  end

  // S0: window shift and fill tracking; clr takes priority over a new sample.
  always_ff @(posedge clk or negedge ngreset) begin
    if (!ngreset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (clr) begin
      win_q  <= '0;
      fill_q <= '0;
    end else if (in_valid) begin
      win_q <= {win_q[WIN-2:0], in_data};
      if (fill_q != WIN_C) fill_q <= fill_q + 4'd1;
    end
  end

  // vld_pipe_q[0]=S0, [1]=S1, [2]=out_valid
  always_ff @(posedge clk or negedge ngreset) begin
    if (!ngreset)  vld_pipe_q <= '0;
    else if (clr)  vld_pipe_q <= '0;
    else           vld_pipe_q <= {vld_pipe_q[STAGES-2:0], in_valid && (fill_q >= FULL_M1)};
  end

  always_ff @(posedge clk or negedge ngreset) begin
    if (!ngreset) begin
      ws1_q  <= '0;
      rank_q <= '0;
    end else if (vld_pipe_q[0] && !clr) begin
      ws1_q  <= win_q;
      rank_q <= rank_d;
    end
  end

  always_comb begin
    med_d = '0;
    for (int i = 0; i < WIN; i++)
      if (rank_q[i] == MID) med_d = ws1_q[i];
  end

  always_ff @(posedge clk or negedge ngreset) begin
    if (!ngreset)                      out_data_q <= '0;
    else if (vld_pipe_q[1] && !clr)    out_data_q <= med_d;
  end

  assign out_valid = vld_pipe_q[STAGES-1];
  assign out_data  = out_data_q;
  assign fill_cnt  = fill_q;

`ifdef MEDIAN_MINMAX_EN
  logic [DW-1:0] min_d, max_d, min_q, max_q, out_min_q, out_max_q;

  always_comb begin
    min_d = win_q[0];
    max_d = win_q[0];
    for (int i = 1; i < WIN; i++) begin
      if (win_q[i] < min_d) min_d = win_q[i];
      if (win_q[i] > max_d) max_d = win_q[i];
    end
  end

  always_ff @(posedge clk or negedge ngreset) begin
    if (!ngreset) begin
      min_q     <= '0;
      max_q     <= '0;
      out_min_q <= '0;
      out_max_q <= '0;
    end else begin
      if (vld_pipe_q[0] && !clr) begin
        min_q <= min_d;
        max_q <= max_d;
      end
      if (vld_pipe_q[1] && !clr) begin
        out_min_q <= min_q;
        out_max_q <= max_q;
      end
    end
  end

  assign out_min = out_min_q;
  assign out_max = out_max_q;
`endif
endmodule

// File: tb/tb_stream_median_filter.sv
// Directed and random stimulus for stream_median_filter against a queue/sort reference model.
// With MEDIAN_MINMAX_EN a second WIN=7 instance checks the min/max outputs.

module tb_stream_median_filter;
  localparam int DW  = 8;
  localparam int WIN = 5;

  logic          clk = 1'b0;
  logic          ngreset = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    fill_cnt;

  always #5 clk = ~clk;

`ifdef MEDIAN_MINMAX_EN
  logic [DW-1:0] out_min, out_max;
  logic          ov7;
  logic [DW-1:0] od7, mn7, mx7;
  logic [3:0]    fc7;

  stream_median_filter #(.DW(DW), .WIN(7)) dut7 (
    .clk(clk), .ngreset(ngreset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov7), .out_data(od7), .fill_cnt(fc7), .out_min(mn7), .out_max(mx7)
  );
`endif

  stream_median_filter #(.DW(DW), .WIN(WIN)) dut (
    .clk(clk), .ngreset(ngreset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .fill_cnt(fill_cnt)
`ifdef MEDIAN_MINMAX_EN
    , .out_min(out_min), .out_max(out_max)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW-1:0] win[$];
  bit            ev[0:4095];
  logic [DW-1:0] ed[0:4095];
  logic [DW-1:0] exp_last = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] median_of_window();
    logic [DW-1:0] s[$];
    s = win;
    s.sort();
    return s[WIN/2];
  endfunction

  // One clock: drive, advance the model, then check every output.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit c = 1'b0);
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    cyc++;
    if (c) begin
      win.delete();
      ev[cyc] = 1'b0; ev[cyc+1] = 1'b0;
    end else if (v) begin
      win.push_front(d);
      if (win.size() > WIN) void'(win.pop_back());
      if (win.size() == WIN) begin
        ev[cyc+2] = 1'b1;
        ed[cyc+2] = median_of_window();
      end
    end
    if (ev[cyc]) exp_last = ed[cyc];
    #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(ev[cyc]));
    chk("out_data", 32'(out_data), 32'(exp_last));
    chk("fill_cnt", 32'(fill_cnt), 32'(win.size()));
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) step(1'b0, '0);
  endtask

  task automatic feed(input logic [DW-1:0] s[$], input int gap);
    foreach (s[k]) begin
      step(1'b1, s[k]);
      for (int g = 0; g < gap; g++) step(1'b0, '0);
    end
  endtask

  initial begin
    logic [DW-1:0] t1[$];
    t1 = '{8'd6, 8'd8, 8'd9, 8'd3, 8'd12, 8'd5, 8'd4};

    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_fill", 32'(fill_cnt), 32'd0);
    #11 ngreset = 1'b1;

    // T1 fill
    feed(t1, 0);
    drain();
    chk("t1_last_median", 32'(out_data), 32'd5);

    // T2 duplicates and extremes
    step(1'b0, '0, 1'b1);
    feed('{8'd7, 8'd7, 8'd255, 8'd0, 8'd7}, 0);
    drain();
    chk("t2_dup_median", 32'(out_data), 32'd7);
    feed('{8'd255, 8'd255}, 0);
    drain();
    chk("t2_max_median", 32'(out_data), 32'd255);

    // T3 gaps
    step(1'b0, '0, 1'b1);
    feed(t1, 2);
    drain();
    chk("t3_gap_median", 32'(out_data), 32'd5);

    // T4 clr drops the pending median
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, t1[k]);
    step(1'b0, '0, 1'b1);
    chk("t4_fill_after_clr", 32'(fill_cnt), 32'd0);
    drain();
    feed('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 0);
    drain();
    chk("t4_median", 32'(out_data), 32'd3);

    // T5 async reset mid-stream
    feed('{8'd40, 8'd50, 8'd60}, 0);
    #2 ngreset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_fill", 32'(fill_cnt), 32'd0);
    win.delete();
    ev[cyc+1] = 1'b0; ev[cyc+2] = 1'b0;
    exp_last = '0;
    #1 ngreset = 1'b1;
    feed('{8'd9, 8'd1, 8'd8, 8'd2, 8'd7}, 0);
    drain();
    chk("t5_refill_median", 32'(out_data), 32'd7);

    // Random stream with gaps and occasional clr
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) step(1'b0, '0, 1'b1);
      else step(1'($urandom_range(0, 3) != 0), DW'($urandom));
    end
    drain();

`ifdef MEDIAN_MINMAX_EN
    // T6 on the WIN=7 instance
    step(1'b0, '0, 1'b1);
    feed('{8'd10, 8'd40, 8'd20, 8'd70, 8'd30, 8'd60, 8'd50}, 0);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t6_valid", 32'(ov7), 32'd1);
    chk("t6_median", 32'(od7), 32'd40);
    chk("t6_min", 32'(mn7), 32'd10);
    chk("t6_max", 32'(mx7), 32'd70);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
